// File: rtl/shift_univ.sv
// Parametrised universal shift register with a counted burst engine.
// Rotate modes (codes 100/101) exist only when SHIFT_UNIV_ROTATE_EN is defined; otherwise they hold.
module shift_univ #(
   parameter  int unsigned WIDTH = 8,
   localparam int unsigned CW    = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [2:0]       sel,
   input  logic             start,
   input  logic [CW-1:0]    amt,
   input  logic [WIDTH-1:0] din,
   input  logic             dinr,
   input  logic             dinl,
   output logic [WIDTH-1:0] out,
   output logic             busy,
   output logic             done
);

   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

   state_e           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [2:0]       mode_q, mode_d;
   logic [WIDTH-1:0] out_q, out_d;
   logic             done_q, done_d;

   // One application of an operation code to the current register value.
   function automatic logic [WIDTH-1:0] step_f(
      input logic [2:0]       op,
      input logic [WIDTH-1:0] v,
      input logic [WIDTH-1:0] d,
      input logic             r,
      input logic             l
   );
      logic [WIDTH-1:0] res;
      res = v;
      case (op)
         3'b000: res = v;
         3'b001: res = {r, v[WIDTH-1:1]};
         3'b010: res = {v[WIDTH-2:0], l};
         3'b011: res = d;
`ifdef SHIFT_UNIV_ROTATE_EN
         3'b100: res = {v[0], v[WIDTH-1:1]};
         3'b101: res = {v[WIDTH-2:0], v[WIDTH-1]};
`else
         3'b100: res = v;
         3'b101: res = v;
`endif
         3'b110: res = {v[WIDTH-1], v[WIDTH-1:1]};
         3'b111: res = '0;
      endcase
      return res;
   endfunction

   // State, counter, latched mode and outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         mode_q  <= '0;
         out_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         mode_q  <= mode_d;
         out_q   <= out_d;
         done_q  <= done_d;
      end
   end

   // Next-state: burst acceptance and step counting.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      mode_d  = mode_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               mode_d = sel;
               if (amt > CW'(1)) begin
                  state_d = BUSY;
                  cnt_d   = amt - CW'(1);
               end
            end
         end
         BUSY: begin
            cnt_d = cnt_q - CW'(1);
            if (cnt_q <= CW'(1)) begin
               state_d = IDLE;
            end
         end
      endcase
   end

   // Output: register update and completion pulse.
   always_comb begin
      out_d  = out_q;
      done_d = 1'b0;
      case (state_q)
         IDLE: begin
            // A zero-length burst performs no step at all.
            if (!start || (amt != CW'(0))) begin
               out_d = step_f(sel, out_q, din, dinr, dinl);
            end
            if (start && (amt <= CW'(1))) begin
               done_d = 1'b1;
            end
         end
         BUSY: begin
            out_d = step_f(mode_q, out_q, din, dinr, dinl);
            if (cnt_q <= CW'(1)) begin
               done_d = 1'b1;
            end
         end
      endcase
   end

   assign out  = out_q;
   assign busy = (state_q == BUSY);
   assign done = done_q;

endmodule

// File: tb/tb_shift_univ.sv
// Self-checking bench for shift_univ (WIDTH=8): vector table, burst sequences and a random direct-mode run.
module tb_shift_univ;

   localparam int unsigned W  = 8;
   localparam int unsigned CW = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [2:0]    sel = '0;
   logic          start = 1'b0;
   logic [CW-1:0] amt = '0;
   logic [W-1:0]  din = '0;
   logic          dinr = 1'b0;
   logic          dinl = 1'b0;
   logic [W-1:0]  out;
   logic          busy;
   logic          done;

   shift_univ #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .sel(sel), .start(start), .amt(amt),
      .din(din), .dinr(dinr), .dinl(dinl), .out(out), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [W-1:0] o;
      logic         b;
      logic         d;
   } exp_t;

   typedef struct {
      logic [2:0]    sel;
      logic          start;
      logic [CW-1:0] amt;
      logic [W-1:0]  din;
      logic          dinr;
      logic          dinl;
      logic [W-1:0]  e_out;
      logic          e_busy;
      logic          e_done;
   } vec_t;

   exp_t sbq[$];
   int   n_vec = 0;
   int   n_err = 0;

`ifdef SHIFT_UNIV_ROTATE_EN
   localparam bit ROT = 1'b1;
`else
   localparam bit ROT = 1'b0;
`endif

   task automatic check_pop(input string nm);
      exp_t e;
      n_vec++;
      if (sbq.size() == 0) begin
         n_err++;
         $display("FAIL %s: scoreboard empty", nm);
         return;
      end
      e = sbq.pop_front();
      if ({out, busy, done} !== e) begin
         n_err++;
         $display("FAIL %s: got out=%h busy=%b done=%b, want out=%h busy=%b done=%b",
                  nm, out, busy, done, e.o, e.b, e.d);
      end
   endtask

   task automatic apply(input logic [2:0] s, input logic st, input logic [CW-1:0] a,
                        input logic [W-1:0] d, input logic r, input logic l,
                        input logic [W-1:0] eo, input logic eb, input logic ed,
                        input string nm);
      @(negedge clk);
      sel = s; start = st; amt = a; din = d; dinr = r; dinl = l;
      sbq.push_back({eo, eb, ed});
      @(posedge clk);
      #1;
      check_pop(nm);
   endtask

   task automatic check_now(input logic [W-1:0] eo, input logic eb, input logic ed, input string nm);
      sbq.push_back({eo, eb, ed});
      check_pop(nm);
   endtask

   function automatic logic [W-1:0] model(input logic [2:0] s, input logic [W-1:0] v,
                                          input logic [W-1:0] d, input logic r, input logic l);
      case (s)
         3'd1:    return {r, v[W-1:1]};
         3'd2:    return {v[W-2:0], l};
         3'd3:    return d;
         3'd4:    return ROT ? {v[0], v[W-1:1]} : v;
         3'd5:    return ROT ? {v[W-2:0], v[W-1]} : v;
         3'd6:    return {v[W-1], v[W-1:1]};
         3'd7:    return '0;
         default: return v;
      endcase
   endfunction

   vec_t vt[$];

   function automatic vec_t mk(input logic [2:0] s, input logic st, input logic [CW-1:0] a,
                               input logic [W-1:0] d, input logic r, input logic l,
                               input logic [W-1:0] eo, input logic eb, input logic ed);
      vec_t v;
      v.sel = s; v.start = st; v.amt = a; v.din = d; v.dinr = r; v.dinl = l;
      v.e_out = eo; v.e_busy = eb; v.e_done = ed;
      return v;
   endfunction

   initial begin
      logic [W-1:0] e;
      logic [W-1:0] rd;
      logic [2:0]   rs;
      logic         rr, rl;

      // Direct-mode and single-step burst vectors.
      vt.push_back(mk(3'd3, 0, 0, 8'hA5, 0, 0, 8'hA5, 0, 0));
      vt.push_back(mk(3'd0, 0, 0, 8'h00, 0, 0, 8'hA5, 0, 0));
      vt.push_back(mk(3'd0, 0, 0, 8'h00, 1, 1, 8'hA5, 0, 0));
      vt.push_back(mk(3'd0, 0, 0, 8'h5A, 0, 0, 8'hA5, 0, 0));
      vt.push_back(mk(3'd3, 0, 0, 8'h80, 0, 0, 8'h80, 0, 0));
      vt.push_back(mk(3'd1, 0, 0, 8'h00, 1, 0, 8'hC0, 0, 0));
      vt.push_back(mk(3'd3, 0, 0, 8'h01, 0, 0, 8'h01, 0, 0));
      vt.push_back(mk(3'd2, 0, 0, 8'h00, 0, 1, 8'h03, 0, 0));
      vt.push_back(mk(3'd2, 0, 0, 8'h00, 1, 0, 8'h06, 0, 0));
      vt.push_back(mk(3'd1, 0, 0, 8'h00, 0, 1, 8'h03, 0, 0));
      vt.push_back(mk(3'd3, 0, 0, 8'h90, 0, 0, 8'h90, 0, 0));
      vt.push_back(mk(3'd6, 0, 0, 8'h00, 0, 0, 8'hC8, 0, 0));
      vt.push_back(mk(3'd6, 0, 0, 8'h00, 0, 0, 8'hE4, 0, 0));
      vt.push_back(mk(3'd7, 0, 0, 8'hFF, 1, 1, 8'h00, 0, 0));
      vt.push_back(mk(3'd3, 0, 0, 8'h81, 0, 0, 8'h81, 0, 0));
      vt.push_back(mk(3'd4, 0, 0, 8'h00, 0, 0, ROT ? 8'hC0 : 8'h81, 0, 0));
      vt.push_back(mk(3'd5, 0, 0, 8'h00, 0, 0, 8'h81, 0, 0));
      vt.push_back(mk(3'd3, 1, 0, 8'hFF, 0, 0, 8'h81, 0, 1));
      vt.push_back(mk(3'd0, 0, 0, 8'h00, 0, 0, 8'h81, 0, 0));
      vt.push_back(mk(3'd3, 1, 1, 8'h3C, 0, 0, 8'h3C, 0, 1));
      vt.push_back(mk(3'd0, 0, 0, 8'h00, 0, 0, 8'h3C, 0, 0));

      #2;
      check_now(8'h00, 0, 0, "reset_state");
      @(negedge clk);
      rst_n = 1'b1;

      foreach (vt[i]) begin
         apply(vt[i].sel, vt[i].start, vt[i].amt, vt[i].din, vt[i].dinr, vt[i].dinl,
               vt[i].e_out, vt[i].e_busy, vt[i].e_done, $sformatf("vec[%0d]", i));
      end

      // Rotate-right burst of 4 from 81.
      apply(3'd3, 0, 0, 8'h81, 0, 0, 8'h81, 0, 0, "rot_load");
      apply(3'd4, 1, 4, 8'h00, 0, 0, ROT ? 8'hC0 : 8'h81, 1, 0, "rot_k0");
      apply(3'd0, 0, 0, 8'h00, 0, 0, ROT ? 8'h60 : 8'h81, 1, 0, "rot_k1");
      apply(3'd7, 1, 2, 8'h00, 0, 0, ROT ? 8'h30 : 8'h81, 1, 0, "rot_k2");
      apply(3'd0, 0, 0, 8'h00, 0, 0, ROT ? 8'h18 : 8'h81, 0, 1, "rot_k3");
      apply(3'd0, 0, 0, 8'h00, 0, 0, ROT ? 8'h18 : 8'h81, 0, 0, "rot_after");

      // Arithmetic burst with sel disturbed; start held through the final edge; back-to-back start.
      apply(3'd3, 0, 0, 8'h90, 0, 0, 8'h90, 0, 0, "asr_load");
      apply(3'd6, 1, 2, 8'h00, 0, 0, 8'hC8, 1, 0, "asr_k0");
      apply(3'd7, 1, 5, 8'h00, 0, 0, 8'hE4, 0, 1, "asr_k1");
      apply(3'd3, 1, 2, 8'h11, 0, 0, 8'h11, 1, 0, "b2b_k0");
      apply(3'd0, 0, 0, 8'h22, 0, 0, 8'h22, 0, 1, "b2b_live_din");
      apply(3'd0, 0, 0, 8'h00, 0, 0, 8'h22, 0, 0, "b2b_after");

      // Shift-left burst longer than WIDTH, filling from dinl.
      apply(3'd7, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, "shl_clear");
      e = 8'h00;
      for (int i = 0; i < 10; i++) begin
         e = {e[W-2:0], 1'b1};
         apply(i == 0 ? 3'd2 : 3'd1, i == 0, 4'd10, 8'h00, 0, 1, e, i < 9, i == 9,
               $sformatf("shl_burst[%0d]", i));
      end

      // Reset in the middle of a rotate-left burst.
      apply(3'd3, 0, 0, 8'hFF, 0, 0, 8'hFF, 0, 0, "rst_load");
      apply(3'd5, 1, 8, 8'h00, 0, 0, 8'hFF, 1, 0, "rst_k0");
      apply(3'd0, 0, 0, 8'h00, 0, 0, 8'hFF, 1, 0, "rst_k1");
      apply(3'd0, 0, 0, 8'h00, 0, 0, 8'hFF, 1, 0, "rst_k2");
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_now(8'h00, 0, 0, "rst_async");
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         apply(3'd0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, $sformatf("rst_no_done[%0d]", i));
      end

      // Random direct-mode operations against a reference model.
      e = 8'h00;
      for (int i = 0; i < 60; i++) begin
         rs = 3'($urandom_range(0, 7));
         rd = 8'($urandom);
         rr = 1'($urandom);
         rl = 1'($urandom);
         e  = model(rs, e, rd, rr, rl);
         apply(rs, 0, 0, rd, rr, rl, e, 0, 0, $sformatf("rand[%0d]", i));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/shift_univ.md
# shift_univ

Parametrised universal shift register, the successor to our fixed 4-bit shift block. It has a configurable width, rotate, arithmetic-shift and clear modes, and a counted burst engine that performs N back-to-back steps from a single `start` pulse. It sits in the datapath wherever serial/parallel conversion or multi-step shifting is needed. Hold, load and single shifts under direct `sel` control behave exactly as in the existing 4-bit block.

## Interface
- `WIDTH`, default 8: register width; legal range ≥ 2.
- `CW`, derived as `$clog2(WIDTH+1)`: width of `amt`. Not to be overridden.

Ports (clock and reset first):
- `clk`  in  1: single clock, rising-edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `sel`  in  3: operation code (see Operation).
- `start`  in  1: burst request, sampled only in IDLE.
- `amt`  in  CW: burst step count, sampled with `start`.
- `din`  in  WIDTH: parallel load data.
- `dinr`  in  1: serial input for right shift; enters at the MSB.
- `dinl`  in  1: serial input for left shift; enters at the LSB.
- `out`  out  WIDTH: register contents.
- `busy`  out  1: burst in progress.
- `done`  out  1: one-cycle pulse after a burst completes.

## Operation
Operation codes (`sel`):
- 000 hold.
- 001 shift right: `{dinr, out[W-1:1]}`.
- 010 shift left: `{out[W-2:0], dinl}`.
- 011 load `din`.
- 100 rotate right.
- 101 rotate left.
- 110 arithmetic shift right (MSB replicated).
- 111 clear to 0.

States:
- IDLE: when `start`=0, each edge applies the current `sel` once (direct mode).
- IDLE, `start`=1 at edge k:
  - The edge applies `sel` once and latches it as the burst mode.
  - cnt <= amt-1 when amt>1, and the block enters BUSY.
  - If amt ≤ 1, the block stays in IDLE and `done` is high after edge k.
- `amt`=0 with `start`: no step at all. `out` holds, and `done` pulses after edge k.
- BUSY:
  - Each edge applies the latched mode, using the live `dinl`/`dinr`/`din`, and decrements cnt.
  - At the edge where cnt=1 → IDLE, `busy` <= 0, `done` <= 1.
- While BUSY, `sel`, `start` and `amt` are ignored. A `start` held high through the final edge of a burst is not accepted until the block is back in IDLE; it is sampled on the next edge.
- The burst mode may be any code. Hold/load/clear simply repeat.
- `amt` > WIDTH is legal. Shifts keep filling from the serial inputs, and rotates wrap modulo WIDTH.

Reset:
- `out`=0, `busy`=0, `done`=0, cnt=0, state IDLE. All take effect immediately on `rst_n` falling.
- Reset mid-burst aborts the burst; no `done` is produced.

## Timing
- Direct mode latency: 1 edge from `sel`/data to `out`.
- Burst of N ≥ 1: steps land on edges k … k+N-1.
- `busy` is high in the N-1 cycles after edge k, until edge k+N-1.
- `done` is high for exactly the one cycle after edge k+N-1, coincident with the final `out` value.
- `done` and `busy` are never high in the same cycle.
- A new `start` may be accepted in the same cycle `done` is high.

## Configuration
- Macro `SHIFT_UNIV_ROTATE_EN`.
- Defined: codes 100/101 rotate as specified.
- Undefined: codes 100/101 decode as hold (000). The burst counter, `busy` and `done` timing are unchanged. Rotate logic is not synthesised.

## Test plan
All scenarios use WIDTH=8.
- Load and hold: `sel`=011, `din`=8'hA5 for one edge, then `sel`=000 for 3 edges → `out`=8'hA5 throughout; `busy`/`done` stay 0.
- Direct shifts: from 8'h80, `sel`=001, `dinr`=1 → 8'hC0. From 8'h01, `sel`=010, `dinl`=1 → 8'h03.
- Rotate burst (macro on): `out`=8'h81, `sel`=100, `start`, `amt`=3 → `out` goes C0, 60, 30. `busy` high for 2 cycles, then `done` high for 1 cycle with `out`=8'h30.
- Arithmetic burst with `sel` disturbed: `out`=8'h90, `sel`=110, `amt`=2. Then `sel`=111 during BUSY → `out` goes C8, E4 (not cleared); `done` pulses once.
- Reset mid-burst: `start` with `amt`=8 from 8'hFF in rotate-left mode; pull `rst_n` low after 3 edges → `out`=0, `busy`=0 immediately; no `done` after release.
- Macro off: `out`=8'h81, `sel`=100, `start`, `amt`=4 → `out` stays 8'h81, `busy` high for 3 cycles, `done` pulses after the 4th edge.
